// File: rtl/layer_io_pkg.sv
// Shared definitions for the layer I/O blocks (input loader and output writer).
package layer_io_pkg;

    // Level-handshake sequencing states shared by the layer I/O engines.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SNAP  = 3'd1,
        WRITE = 3'd2,
        PRED  = 3'd3,
        DONE  = 3'd4
    } state_t;

    // Default sizes for the classifier output stage.
    localparam int DEFAULT_OUTPUT_SIZE = 10;
    localparam int DEFAULT_IN_WIDTH    = 8;
    localparam int DEFAULT_DATA_WIDTH  = 32;

endpackage

// File: rtl/argmax_tracker.sv
// Running signed maximum with the index where it was first seen.
module argmax_tracker #(
    parameter int VAL_WIDTH = 8,
    parameter int IDX_WIDTH = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        clear_load,
    input  logic signed [VAL_WIDTH-1:0] load_val,
    input  logic                        sample_valid,
    input  logic signed [VAL_WIDTH-1:0] sample_val,
    input  logic        [IDX_WIDTH-1:0] sample_idx,
    output logic signed [VAL_WIDTH-1:0] max_val,
    output logic        [IDX_WIDTH-1:0] max_idx
);

    // Seed with element 0 on load; afterwards replace only on a strictly greater value,
    // so ties keep the lowest index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            max_val <= '0;
            max_idx <= '0;
        end else if (clear_load) begin
            max_val <= load_val;
            max_idx <= '0;
        end else if (sample_valid && (sample_val > max_val)) begin
            max_val <= sample_val;
            max_idx <= sample_idx;
        end
    end

endmodule

// File: rtl/output_layer_writer.sv
// Streams the final-layer logits into the output RAM, then appends the argmax class.
module output_layer_writer
    import layer_io_pkg::*;
#(
    parameter int OUTPUT_SIZE = DEFAULT_OUTPUT_SIZE,
    parameter int IN_WIDTH    = DEFAULT_IN_WIDTH,
    parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 start,
    output logic                                 done,
    input  logic signed [IN_WIDTH-1:0]           layer_in [OUTPUT_SIZE-1:0],
    output logic                                 outputs_write_en,
    output logic [$clog2(OUTPUT_SIZE+1)-1:0]     outputs_write_address,
    output logic [DATA_WIDTH-1:0]                outputs_write_data,
    output logic [$clog2(OUTPUT_SIZE)-1:0]       prediction,
    output logic                                 prediction_valid
);

    localparam int AW = $clog2(OUTPUT_SIZE + 1);
    localparam int PW = $clog2(OUTPUT_SIZE);
    localparam logic [AW-1:0] LAST_IDX  = AW'(OUTPUT_SIZE - 1);
    localparam logic [AW-1:0] PRED_ADDR = AW'(OUTPUT_SIZE);

    state_t                        state, state_next;
    logic [AW-1:0]                 idx;
    logic signed [IN_WIDTH-1:0]    snap [OUTPUT_SIZE-1:0];
    logic signed [IN_WIDTH-1:0]    cur_val;
    logic signed [DATA_WIDTH-1:0]  cur_ext;
    logic signed [IN_WIDTH-1:0]    max_val;
    logic [PW-1:0]                 max_idx;

    // Current snapshot element and its sign-extended RAM word.
    always_comb begin
        cur_val = snap[idx];
        cur_ext = DATA_WIDTH'(cur_val);
    end

    // Next-state logic for the start/done level handshake.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = SNAP;
            SNAP:    state_next = WRITE;
            WRITE:   if (idx == LAST_IDX) state_next = PRED;
            PRED:    state_next = DONE;
            DONE:    if (!start) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Logit index: walks 0..OUTPUT_SIZE-1 during WRITE and parks at the last index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx <= '0;
        end else if (state == WRITE) begin
            if (idx != LAST_IDX) idx <= idx + 1'b1;
        end else begin
            idx <= '0;
        end
    end

    // Snapshot of the logits, taken once so later input changes cannot leak into the stream.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < OUTPUT_SIZE; i++) snap[i] <= '0;
        end else if (state == SNAP) begin
            for (int unsigned i = 0; i < OUTPUT_SIZE; i++) snap[i] <= layer_in[i];
        end
    end

    // Seeded from layer_in[0] in SNAP: the same value snap[0] receives on that edge.
    argmax_tracker #(
        .VAL_WIDTH (IN_WIDTH),
        .IDX_WIDTH (PW)
    ) u_argmax (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear_load   (state == SNAP),
        .load_val     (layer_in[0]),
        .sample_valid (state == WRITE),
        .sample_val   (cur_val),
        .sample_idx   (PW'(idx)),
        .max_val      (max_val),
        .max_idx      (max_idx)
    );

    // Registered RAM port, prediction and done outputs.
    // done is qualified by start so it drops on the edge that sees start released.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outputs_write_en      <= 1'b0;
            outputs_write_address <= '0;
            outputs_write_data    <= '0;
            prediction            <= '0;
            prediction_valid      <= 1'b0;
            done                  <= 1'b0;
        end else begin
            outputs_write_en <= 1'b0;
            done             <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) prediction_valid <= 1'b0;
                end
                WRITE: begin
                    outputs_write_en      <= 1'b1;
                    outputs_write_address <= idx;
                    outputs_write_data    <= cur_ext;
                end
                PRED: begin
                    outputs_write_en      <= 1'b1;
                    outputs_write_address <= PRED_ADDR;
                    outputs_write_data    <= DATA_WIDTH'(max_idx);
                    prediction            <= max_idx;
                    prediction_valid      <= 1'b1;
                end
                DONE: begin
                    done <= start;
                end
                default: ;
            endcase
        end
    end

    // max_val is only observed inside the tracker's compare.
    logic unused_max;
    assign unused_max = ^max_val;

endmodule

// File: tb/tb_output_layer_writer.sv
// Directed + randomized bench for output_layer_writer against a behavioural reference.
module tb_output_layer_writer;

    localparam int N  = 10;
    localparam int IW = 8;
    localparam int DW = 32;

    logic                   clk;
    logic                   rst_n;
    logic                   start;
    logic                   done;
    logic signed [IW-1:0]   layer_in [N-1:0];
    logic                   outputs_write_en;
    logic [3:0]             outputs_write_address;
    logic [DW-1:0]          outputs_write_data;
    logic [3:0]             prediction;
    logic                   prediction_valid;

    int errors = 0;
    int checks = 0;

    logic [3:0]  wa_q [$];
    logic [31:0] wd_q [$];

    output_layer_writer #(
        .OUTPUT_SIZE (N),
        .IN_WIDTH    (IW),
        .DATA_WIDTH  (DW)
    ) dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .start                 (start),
        .done                  (done),
        .layer_in              (layer_in),
        .outputs_write_en      (outputs_write_en),
        .outputs_write_address (outputs_write_address),
        .outputs_write_data    (outputs_write_data),
        .prediction            (prediction),
        .prediction_valid      (prediction_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every RAM write seen on the falling edge.
    always @(negedge clk) begin
        if (outputs_write_en) begin
            wa_q.push_back(outputs_write_address);
            wd_q.push_back(outputs_write_data);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One full request: model the expected word stream from the logits present at start,
    // then compare latency, writes, prediction and the done handshake.
    task automatic run(input string tag, input bit scramble, input int hold);
        logic signed [IW-1:0] m [N];
        logic [31:0] exp_data;
        int n;
        int best;
        for (int i = 0; i < N; i++) m[i] = layer_in[i];
        best = 0;
        for (int i = 1; i < N; i++) if (m[i] > m[best]) best = i;
        wa_q.delete();
        wd_q.delete();
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check({tag, "_pv_cleared"}, 32'(prediction_valid), 32'd0);
        n = 0;
        do begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (scramble && n == 1)
                for (int i = 0; i < N; i++) layer_in[i] = IW'($urandom);
        end while (!done && n < 40);
        check({tag, "_latency"}, 32'(n), 32'(N + 3));
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_pv"}, 32'(prediction_valid), 32'd1);
        check({tag, "_pred"}, 32'(prediction), 32'(best));
        check({tag, "_nwrites"}, 32'(wa_q.size()), 32'(N + 1));
        for (int i = 0; i <= N; i++) begin
            if (i < wa_q.size()) begin
                exp_data = (i < N) ? 32'(int'(m[i])) : 32'(best);
                check($sformatf("%s_addr%0d", tag, i), 32'(wa_q[i]), 32'(i));
                check($sformatf("%s_data%0d", tag, i), wd_q[i], exp_data);
            end
        end
        if (hold > 0) begin
            repeat (hold) @(negedge clk);
            check({tag, "_hold_done"}, 32'(done), 32'd1);
            check({tag, "_hold_nwrites"}, 32'(wa_q.size()), 32'(N + 1));
        end
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check({tag, "_done_fall"}, 32'(done), 32'd0);
        @(negedge clk);
        check({tag, "_final_nwrites"}, 32'(wa_q.size()), 32'(N + 1));
    endtask

    initial begin : stim
        int n;
        logic signed [IW-1:0] t1 [N];
        t1 = '{-8'sd3, 8'sd5, 8'sd127, -8'sd128, 8'sd0, 8'sd1, 8'sd2, 8'sd3, 8'sd4, 8'sd5};
        rst_n = 1'b0;
        start = 1'b0;
        for (int i = 0; i < N; i++) layer_in[i] = '0;
        repeat (3) @(negedge clk);
        check("rst_we", 32'(outputs_write_en), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_data", outputs_write_data, 32'd0);
        check("rst_pv", 32'(prediction_valid), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // T1: mixed logits incl. extremes.
        for (int i = 0; i < N; i++) layer_in[i] = t1[i];
        run("t1", 1'b0, 0);

        // T2: all equal, tie keeps index 0.
        for (int i = 0; i < N; i++) layer_in[i] = -8'sd7;
        run("t2", 1'b0, 0);

        // T3: max in the last slot.
        for (int i = 0; i < N; i++) layer_in[i] = '0;
        layer_in[N-1] = 8'sd100;
        run("t3", 1'b0, 0);

        // T4: inputs change one cycle after SNAP.
        for (int i = 0; i < N; i++) layer_in[i] = IW'($urandom);
        run("t4", 1'b1, 0);

        // Random logit vectors.
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < N; i++) layer_in[i] = IW'($urandom);
            run($sformatf("rnd%0d", r), 1'b0, 0);
        end

        // T5: async reset during the fifth write.
        for (int i = 0; i < N; i++) layer_in[i] = IW'($urandom);
        start = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(outputs_write_en && outputs_write_address == 4'd4) && n < 40);
        check("t5_reach_write4", 32'(n < 40), 32'd1);
        rst_n = 1'b0;
        #1;
        check("t5_we", 32'(outputs_write_en), 32'd0);
        check("t5_addr", 32'(outputs_write_address), 32'd0);
        check("t5_data", outputs_write_data, 32'd0);
        check("t5_done", 32'(done), 32'd0);
        check("t5_pred", 32'(prediction), 32'd0);
        check("t5_pv", 32'(prediction_valid), 32'd0);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run("t5_rerun", 1'b0, 0);

        // T6: start held 20 cycles past done.
        for (int i = 0; i < N; i++) layer_in[i] = IW'($urandom);
        run("t6", 1'b0, 20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
